// File: rtl/riscv_multicycle.sv
// Multi-cycle RV32I-subset core: one unified word memory, shared ALU, one FSM state per cycle,
// with host program-load port, start/halt control, sticky done/err and a retired counter.
module riscv_multicycle #(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned NREGS     = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         load_we,
    input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
    input  logic [31:0]                  load_wdata,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [31:0]                  pc,
    output logic [31:0]                  retired
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned RW = $clog2(NREGS);

    typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;
    state_e state_q, state_d;

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] rf  [NREGS];
    logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q, retired_q;
    logic        done_q, err_q;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_i, imm_s, imm_b, rs1_val, rs2_val, alu_out;
    logic        is_r, is_addi, is_lw, is_sw, is_beq, is_ecall, legal, regs_ok, misaligned, ctrl;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];
    assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

    // Indices beyond NREGS read as zero; decode rejects them before any write.
    assign rs1_val = (rs1 == 5'd0 || 32'(rs1) >= NREGS) ? 32'd0 : rf[rs1[RW-1:0]];
    assign rs2_val = (rs2 == 5'd0 || 32'(rs2) >= NREGS) ? 32'd0 : rf[rs2[RW-1:0]];

    always_comb begin
        is_r     = (opcode == 7'b0110011) &&
                   (((funct7 == 7'b0000000) && (funct3 inside {3'b000, 3'b010, 3'b110, 3'b111})) ||
                    ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
        is_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
        is_lw    = (opcode == 7'b0000011) && (funct3 == 3'b010);
        is_sw    = (opcode == 7'b0100011) && (funct3 == 3'b010);
        is_beq   = (opcode == 7'b1100011) && (funct3 == 3'b000);
        is_ecall = (ir_q == 32'h0000_0073);
        legal    = is_r || is_addi || is_lw || is_sw || is_beq || is_ecall;
        regs_ok  = !(((is_r || is_addi || is_lw || is_sw || is_beq) && 32'(rs1) >= NREGS) ||
                     ((is_r || is_sw || is_beq) && 32'(rs2) >= NREGS) ||
                     ((is_r || is_addi || is_lw) && 32'(rd) >= NREGS));
    end

    always_comb begin
        alu_out = a_q + imm_i;
        if (is_sw) begin
            alu_out = a_q + imm_s;
        end else if (is_r) begin
            case (funct3)
                3'b111:  alu_out = a_q & b_q;
                3'b110:  alu_out = a_q | b_q;
                3'b010:  alu_out = {31'd0, $signed(a_q) < $signed(b_q)};
                default: alu_out = funct7[5] ? a_q - b_q : a_q + b_q;
            endcase
        end
    end

    assign misaligned = (is_lw || is_sw) && (alu_out[1:0] != 2'b00);
    assign ctrl       = (state_q == StIdle) || (state_q == StHalt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StHalt: if (start) state_d = StFetch;
            StFetch:        state_d = StDecode;
            StDecode:       state_d = (!legal || !regs_ok || is_ecall) ? StHalt : StExec;
            StExec: begin
                if (is_beq)                 state_d = StFetch;
                else if (misaligned)        state_d = StHalt;
                else if (is_lw || is_sw)    state_d = StMem;
                else                        state_d = StWb;
            end
            StMem:          state_d = is_sw ? StFetch : StWb;
            StWb:           state_d = StFetch;
            default:        state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = !ctrl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            retired_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StHalt: begin
                    if (start) begin
                        pc_q      <= RESET_PC;
                        retired_q <= '0;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                    end
                end
                StFetch: ir_q <= mem[pc_q[AW+1:2]];
                StDecode: begin
                    a_q <= rs1_val;
                    b_q <= rs2_val;
                    if (!legal || !regs_ok) begin
                        err_q <= 1'b1;
                    end else if (is_ecall) begin
                        done_q    <= 1'b1;
                        retired_q <= retired_q + 32'd1;
                    end
                end
                StExec: begin
                    alu_q <= alu_out;
                    if (is_beq) begin
                        pc_q      <= (a_q == b_q) ? pc_q + imm_b : pc_q + 32'd4;
                        retired_q <= retired_q + 32'd1;
                    end else if (misaligned) begin
                        err_q <= 1'b1;
                    end
                end
                StMem: begin
                    if (is_sw) begin
                        pc_q      <= pc_q + 32'd4;
                        retired_q <= retired_q + 32'd1;
                    end else begin
                        mdr_q <= mem[alu_q[AW+1:2]];
                    end
                end
                StWb: begin
                    pc_q      <= pc_q + 32'd4;
                    retired_q <= retired_q + 32'd1;
                end
                default: ;
            endcase
        end
    end

    // Memory has no reset; host writes are only honoured while the core is parked.
    always_ff @(posedge clk) begin
        if (load_we && ctrl) begin
            mem[load_addr] <= load_wdata;
        end else if (state_q == StMem && is_sw) begin
            mem[alu_q[AW+1:2]] <= b_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (state_q == StWb && rd != 5'd0) begin
            rf[rd[RW-1:0]] <= is_lw ? mdr_q : alu_q;
        end
    end

    assign pc      = pc_q;
    assign retired = retired_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_riscv_multicycle.sv
// Bench for riscv_multicycle: directed vector table, hand-written control/reset sequences and
// random programs checked against an instruction-level interpreter.
module tb_riscv_multicycle;
    logic        clk, rst_n, start, start_e, load_we;
    logic [7:0]  load_addr;
    logic [31:0] load_wdata;
    logic        busy, done, err, busy_e, done_e, err_e;
    logic [31:0] pc, retired, pc_e, retired_e;

    riscv_multicycle #(.MEM_WORDS(256), .NREGS(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .load_we(load_we), .load_addr(load_addr),
        .load_wdata(load_wdata), .busy(busy), .done(done), .err(err), .pc(pc), .retired(retired)
    );

    riscv_multicycle #(.MEM_WORDS(256), .NREGS(16), .RESET_PC(32'h0)) dut_e (
        .clk(clk), .rst_n(rst_n), .start(start_e), .load_we(load_we), .load_addr(load_addr),
        .load_wdata(load_wdata), .busy(busy_e), .done(done_e), .err(err_e), .pc(pc_e),
        .retired(retired_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] ECALL = 32'h0000_0073;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] m_rf  [32];
    logic [31:0] m_mem [256];

    typedef struct {
        logic [7:0][31:0] prog;
        int               nwords;
        int               ra;
        logic [31:0]      ea;
        int               rb;
        logic [31:0]      eb;
        int               mi;
        logic [31:0]      em;
        bit               ed;
        bit               ee;
        logic [31:0]      eret;
        logic [31:0]      epc;
        int               ecyc;  // -1: not checked
    } vec_t;
    vec_t vt [9];

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                          input int rd, input logic [6:0] op);
        logic [11:0] i12 = imm[11:0];
        return {i12, rs1[4:0], f3, rd[4:0], op};
    endfunction
    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 3'd0, rd, 7'h13);
    endfunction
    function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 3'd2, rd, 7'h03);
    endfunction
    function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
        logic [11:0] i12 = imm[11:0];
        return {i12[11:5], rs2[4:0], rs1[4:0], 3'd2, i12[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] beq(input int rs1, input int rs2, input int off);
        logic [12:0] o = off[12:0];
        return {o[12], o[10:5], rs2[4:0], rs1[4:0], 3'd0, o[4:1], o[11], 7'h63};
    endfunction
    // sel: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
    function automatic logic [31:0] rop(input int sel, input int rd, input int rs1, input int rs2);
        logic [2:0] f3;
        logic [6:0] f7;
        f7 = (sel == 1) ? 7'h20 : 7'h00;
        case (sel)
            2:       f3 = 3'd7;
            3:       f3 = 3'd6;
            4:       f3 = 3'd2;
            default: f3 = 3'd0;
        endcase
        return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'h33};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    task automatic load_word(input int idx, input logic [31:0] w);
        load_we = 1'b1; load_addr = idx[7:0]; load_wdata = w;
        @(posedge clk); #1;
        load_we = 1'b0;
        m_mem[idx] = w;
    endtask

    task automatic run_prog(input string nm, output int cyc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 3000) begin
            cyc++;
            @(posedge clk); #1;
        end
        chk({nm, ".halted"}, {31'd0, busy}, 32'd0);
    endtask

    // Instruction-level interpreter over m_rf/m_mem; returns halt status and cycle cost.
    task automatic model_run(output int cyc, output bit md, output bit me,
                             output logic [31:0] mpc, output logic [31:0] mret);
        logic [31:0] p, ins, a, b, res, addr, ii, is, ib;
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        bit          stop, wr;
        p = 32'd0; cyc = 0; md = 0; me = 0; mret = 0; stop = 0;
        for (int s = 0; s < 2000 && !stop; s++) begin
            ins = m_mem[p[9:2]];
            rd = ins[11:7]; r1 = ins[19:15]; r2 = ins[24:20]; f3 = ins[14:12]; f7 = ins[31:25];
            a  = (r1 == 0) ? 32'd0 : m_rf[r1];
            b  = (r2 == 0) ? 32'd0 : m_rf[r2];
            ii = {{20{ins[31]}}, ins[31:20]};
            is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            wr = 0; res = 32'd0;
            if (ins == ECALL) begin
                cyc += 2; mret++; md = 1; stop = 1;
            end else if (ins[6:0] == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin
                res = a - b; wr = 1; cyc += 4;
            end else if (ins[6:0] == 7'h33 && f7 == 7'h00 && f3 == 3'd0) begin
                res = a + b; wr = 1; cyc += 4;
            end else if (ins[6:0] == 7'h33 && f7 == 7'h00 && f3 == 3'd7) begin
                res = a & b; wr = 1; cyc += 4;
            end else if (ins[6:0] == 7'h33 && f7 == 7'h00 && f3 == 3'd6) begin
                res = a | b; wr = 1; cyc += 4;
            end else if (ins[6:0] == 7'h33 && f7 == 7'h00 && f3 == 3'd2) begin
                res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; wr = 1; cyc += 4;
            end else if (ins[6:0] == 7'h13 && f3 == 3'd0) begin
                res = a + ii; wr = 1; cyc += 4;
            end else if (ins[6:0] == 7'h03 && f3 == 3'd2) begin
                addr = a + ii;
                if (addr[1:0] != 2'b00) begin me = 1; stop = 1; end
                else begin res = m_mem[addr[9:2]]; wr = 1; cyc += 5; end
            end else if (ins[6:0] == 7'h23 && f3 == 3'd2) begin
                addr = a + is;
                if (addr[1:0] != 2'b00) begin me = 1; stop = 1; end
                else begin m_mem[addr[9:2]] = b; cyc += 4; mret++; p += 4; end
            end else if (ins[6:0] == 7'h63 && f3 == 3'd0) begin
                p = (a == b) ? p + ib : p + 4; cyc += 3; mret++;
            end else begin
                me = 1; stop = 1;
            end
            if (wr) begin
                if (rd != 0) m_rf[rd] = res;
                p += 4; mret++;
            end
        end
        mpc = p;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cyc, mcyc, n, kind, rdv, rav, rbv;
        bit md, me;
        logic [31:0] mpc, mret, w;

        rst_n = 1'b0; start = 1'b0; start_e = 1'b0; load_we = 1'b0;
        load_addr = '0; load_wdata = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;

        for (int i = 0; i < 9; i++) vt[i].prog = '0;
        vt[0].prog[0] = addi(1, 0, 5);  vt[0].prog[1] = addi(2, 0, -3);
        vt[0].prog[2] = rop(0, 3, 1, 2); vt[0].prog[3] = rop(4, 4, 2, 1); vt[0].prog[4] = ECALL;
        vt[0].nwords = 5; vt[0].ra = 3; vt[0].ea = 32'd2; vt[0].rb = 4; vt[0].eb = 32'd1;
        vt[0].mi = 4; vt[0].em = ECALL; vt[0].ed = 1; vt[0].ee = 0; vt[0].eret = 5;
        vt[0].epc = 16; vt[0].ecyc = 18;
        vt[1].prog[0] = lw(1, 0, 24);   vt[1].prog[1] = beq(0, 0, 8);
        vt[1].prog[3] = sw(1, 0, 8);    vt[1].prog[4] = lw(5, 0, 8);
        vt[1].prog[5] = ECALL;          vt[1].prog[6] = 32'hDEAD_BEEF;
        vt[1].nwords = 7; vt[1].ra = 5; vt[1].ea = 32'hDEAD_BEEF; vt[1].rb = 1;
        vt[1].eb = 32'hDEAD_BEEF; vt[1].mi = 2; vt[1].em = 32'hDEAD_BEEF; vt[1].ed = 1;
        vt[1].ee = 0; vt[1].eret = 5; vt[1].epc = 20; vt[1].ecyc = 19;
        vt[2].prog[0] = lw(6, 0, 24);   vt[2].prog[1] = ECALL; vt[2].prog[6] = 32'h0BAD_F00D;
        vt[2].nwords = 7; vt[2].ra = 6; vt[2].ea = 32'h0BAD_F00D; vt[2].rb = 0; vt[2].eb = 0;
        vt[2].mi = 6; vt[2].em = 32'h0BAD_F00D; vt[2].ed = 1; vt[2].ee = 0; vt[2].eret = 2;
        vt[2].epc = 4; vt[2].ecyc = 7;
        vt[3].prog[0] = addi(1, 0, 12); vt[3].prog[1] = addi(2, 0, 10);
        vt[3].prog[2] = rop(2, 3, 1, 2); vt[3].prog[3] = rop(3, 4, 1, 2); vt[3].prog[4] = ECALL;
        vt[3].nwords = 5; vt[3].ra = 3; vt[3].ea = 32'd8; vt[3].rb = 4; vt[3].eb = 32'd14;
        vt[3].mi = 0; vt[3].em = addi(1, 0, 12); vt[3].ed = 1; vt[3].ee = 0; vt[3].eret = 5;
        vt[3].epc = 16; vt[3].ecyc = 18;
        vt[4].prog[0] = addi(6, 0, 1);  vt[4].prog[1] = addi(0, 0, 9);
        vt[4].prog[2] = rop(0, 6, 0, 0); vt[4].prog[3] = addi(8, 0, -1);
        vt[4].prog[4] = rop(4, 9, 8, 0); vt[4].prog[5] = ECALL;
        vt[4].nwords = 6; vt[4].ra = 6; vt[4].ea = 32'd0; vt[4].rb = 9; vt[4].eb = 32'd1;
        vt[4].mi = 5; vt[4].em = ECALL; vt[4].ed = 1; vt[4].ee = 0; vt[4].eret = 6;
        vt[4].epc = 20; vt[4].ecyc = 22;
        vt[5].prog[0] = addi(1, 0, 1);  vt[5].prog[1] = beq(1, 0, 8);
        vt[5].prog[2] = rop(1, 2, 0, 1); vt[5].prog[3] = ECALL;
        vt[5].nwords = 4; vt[5].ra = 2; vt[5].ea = 32'hFFFF_FFFF; vt[5].rb = 1; vt[5].eb = 32'd1;
        vt[5].mi = 3; vt[5].em = ECALL; vt[5].ed = 1; vt[5].ee = 0; vt[5].eret = 4;
        vt[5].epc = 12; vt[5].ecyc = 13;
        vt[6].prog[0] = addi(1, 0, 3);  vt[6].prog[1] = beq(1, 0, 12);
        vt[6].prog[2] = addi(1, 1, -1); vt[6].prog[3] = beq(0, 0, -8); vt[6].prog[4] = ECALL;
        vt[6].nwords = 5; vt[6].ra = 1; vt[6].ea = 32'd0; vt[6].rb = 0; vt[6].eb = 32'd0;
        vt[6].mi = 4; vt[6].em = ECALL; vt[6].ed = 1; vt[6].ee = 0; vt[6].eret = 12;
        vt[6].epc = 16; vt[6].ecyc = 39;
        vt[7].prog[0] = 32'hFFFF_FFFF;
        vt[7].nwords = 1; vt[7].ra = 0; vt[7].ea = 32'd0; vt[7].rb = 6; vt[7].eb = 32'd0;
        vt[7].mi = 0; vt[7].em = 32'hFFFF_FFFF; vt[7].ed = 0; vt[7].ee = 1; vt[7].eret = 0;
        vt[7].epc = 0; vt[7].ecyc = -1;
        vt[8].prog[0] = addi(7, 0, 77); vt[8].prog[1] = lw(7, 0, 6); vt[8].prog[2] = ECALL;
        vt[8].nwords = 3; vt[8].ra = 7; vt[8].ea = 32'd77; vt[8].rb = 1; vt[8].eb = 32'd0;
        vt[8].mi = 1; vt[8].em = lw(7, 0, 6); vt[8].ed = 0; vt[8].ee = 1; vt[8].eret = 1;
        vt[8].epc = 4; vt[8].ecyc = -1;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst.busy", {31'd0, busy}, 0);    chk("rst.done", {31'd0, done}, 0);
        chk("rst.err", {31'd0, err}, 0);      chk("rst.pc", pc, 0);
        chk("rst.retired", retired, 0);       chk("rst.x5", dut.rf[5], 0);

        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < vt[i].nwords; k++) load_word(k, vt[i].prog[k]);
            run_prog($sformatf("v%0d", i), cyc);
            chk($sformatf("v%0d.done", i), {31'd0, done}, {31'd0, vt[i].ed});
            chk($sformatf("v%0d.err", i), {31'd0, err}, {31'd0, vt[i].ee});
            chk($sformatf("v%0d.retired", i), retired, vt[i].eret);
            chk($sformatf("v%0d.pc", i), pc, vt[i].epc);
            if (vt[i].ecyc >= 0) chk($sformatf("v%0d.cycles", i), cyc, vt[i].ecyc);
            chk($sformatf("v%0d.x%0d", i, vt[i].ra), dut.rf[vt[i].ra], vt[i].ea);
            chk($sformatf("v%0d.x%0d", i, vt[i].rb), dut.rf[vt[i].rb], vt[i].eb);
            chk($sformatf("v%0d.mem%0d", i, vt[i].mi), dut.mem[vt[i].mi], vt[i].em);
        end

        // Load and start are ignored while busy.
        load_word(100, 32'h1234_5678);
        load_word(0, addi(1, 0, 5));  load_word(1, addi(2, 0, -3));
        load_word(2, rop(0, 3, 1, 2)); load_word(3, rop(4, 4, 2, 1)); load_word(4, ECALL);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        cyc = 0;
        while (busy && cyc < 3000) begin
            cyc++;
            if (cyc == 4) begin
                load_we = 1'b1; load_addr = 8'd100; load_wdata = 32'hCAFE_F00D; start = 1'b1;
            end else if (cyc == 6) begin
                load_we = 1'b1; load_addr = 8'd4; load_wdata = 32'hFFFF_FFFF;
            end
            @(posedge clk); #1;
            load_we = 1'b0; start = 1'b0;
        end
        chk("gate.halted", {31'd0, busy}, 0);     chk("gate.cycles", cyc, 18);
        chk("gate.done", {31'd0, done}, 1);       chk("gate.err", {31'd0, err}, 0);
        chk("gate.retired", retired, 5);          chk("gate.mem100", dut.mem[100], 32'h1234_5678);
        chk("gate.mem4", dut.mem[4], ECALL);

        // Restart from HALT clears status and re-runs.
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        chk("rerun.retired0", retired, 0);        chk("rerun.done0", {31'd0, done}, 0);
        chk("rerun.busy", {31'd0, busy}, 1);
        cyc = 1;
        while (busy && cyc < 3000) begin cyc++; @(posedge clk); #1; end
        chk("rerun.retired", retired, 5);         chk("rerun.done", {31'd0, done}, 1);
        chk("rerun.x3", dut.rf[3], 2);

        // Load and start in the same cycle: the fetch sees the new word.
        load_we = 1'b1; load_addr = 8'd0; load_wdata = ECALL; start = 1'b1;
        @(posedge clk); #1;
        load_we = 1'b0; start = 1'b0; m_mem[0] = ECALL;
        cyc = 0;
        while (busy && cyc < 3000) begin cyc++; @(posedge clk); #1; end
        chk("ldst.cycles", cyc, 2);               chk("ldst.retired", retired, 1);
        chk("ldst.done", {31'd0, done}, 1);       chk("ldst.pc", pc, 0);

        // RV32E instance rejects x20.
        load_word(0, addi(20, 0, 1));
        start_e = 1'b1; @(posedge clk); #1; start_e = 1'b0;
        cyc = 0;
        while (busy_e && cyc < 100) begin cyc++; @(posedge clk); #1; end
        chk("rv32e.halted", {31'd0, busy_e}, 0);  chk("rv32e.err", {31'd0, err_e}, 1);
        chk("rv32e.done", {31'd0, done_e}, 0);    chk("rv32e.pc", pc_e, 0);
        chk("rv32e.retired", retired_e, 0);

        // Async reset during the MEM state of a store.
        load_word(10, 32'hA5A5_A5A5);
        load_word(0, addi(1, 0, 32'h55)); load_word(1, sw(1, 0, 40)); load_word(2, ECALL);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        chk("arst.pre_retired", retired, 1);      chk("arst.pre_busy", {31'd0, busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.busy", {31'd0, busy}, 0);       chk("arst.done", {31'd0, done}, 0);
        chk("arst.err", {31'd0, err}, 0);         chk("arst.pc", pc, 0);
        chk("arst.retired", retired, 0);          chk("arst.x1", dut.rf[1], 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst.mem10", dut.mem[10], 32'hA5A5_A5A5);
        for (int i = 0; i < 32; i++) m_rf[i] = '0;

        // Random programs against the interpreter.
        for (int k = 64; k < 72; k++) load_word(k, $urandom);
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(6, 14);
            for (int i = 0; i < n; i++) begin
                kind = $urandom_range(0, 5);
                rdv = $urandom_range(1, 7); rav = $urandom_range(0, 7); rbv = $urandom_range(0, 7);
                case (kind)
                    1: w = rop($urandom_range(0, 4), rdv, rav, rbv);
                    2: w = sw(rbv, 0, 256 + 4 * $urandom_range(0, 7));
                    3: w = lw(rdv, 0, 256 + 4 * $urandom_range(0, 7));
                    4: w = beq(rav % 4, rbv % 4, 4 * $urandom_range(1, n - i));
                    default: w = addi(rdv, rav, $urandom_range(0, 4095));
                endcase
                load_word(i, w);
            end
            load_word(n, ECALL);
            model_run(mcyc, md, me, mpc, mret);
            run_prog($sformatf("rnd%0d", t), cyc);
            chk($sformatf("rnd%0d.done", t), {31'd0, done}, {31'd0, md});
            chk($sformatf("rnd%0d.err", t), {31'd0, err}, {31'd0, me});
            chk($sformatf("rnd%0d.retired", t), retired, mret);
            chk($sformatf("rnd%0d.pc", t), pc, mpc);
            chk($sformatf("rnd%0d.cycles", t), cyc, mcyc);
            for (int r = 1; r < 8; r++) chk($sformatf("rnd%0d.x%0d", t, r), dut.rf[r], m_rf[r]);
            for (int k = 64; k < 72; k++)
                chk($sformatf("rnd%0d.mem%0d", t, k), dut.mem[k], m_mem[k]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
